lsu_mem_ctrl: RTL and testbench

Load/store unit controller that consumes the MEM-stage pipeline register outputs: memory op, store enable, ALU address and rs2 store data.
- Drives a request/grant/response data-memory port and returns formatted load data to the writeback mux.
- Asserts stall_o to hold the MEM-stage pipeline register enable low until each access completes.
- Byte-lane steering, load sign/zero extension, misalignment/illegal-op faulting and a response watchdog are all handled here.

---
 rtl/lsu_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store unit controller sitting behind the MEM-stage pipeline register.
// Turns a load/store instruction into one request/grant/response transaction
// on the data-memory port, steers store bytes onto the right lanes, formats
// returned load data (sign/zero extension) and holds the pipeline (stall_o)
// until the access has completed. Misaligned and illegal ops are faulted
// without touching memory, and a watchdog aborts accesses that never finish.
//
// Ports
//   clk_i, reset_ni          clock (rising edge), async active-low reset
//   ld_en_i, mem_wren_i      MEM-stage load / store qualifiers (store wins)
//   mem_op_i[2:0]            funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   addr_i[31:0]             byte address from the ALU
//   st_data_i[31:0]          store data (rs2)
//   stall_o                  hold the MEM-stage register while busy
//   fault_o                  misaligned / illegal access (combinational)
//   timeout_o                one-cycle pulse when the watchdog aborts
//   ld_data_o[31:0]          formatted load data (registered)
//   dmem_req_o .. dmem_wdata_o  request side of the data-memory port
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i  grant / response side
//
// Parameter
//   TIMEOUT  cycles allowed from the first request cycle to the response
//            before the access is aborted; 0 disables the watchdog.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int unsigned TIMEOUT = 256
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        ld_en_i,
    input  logic        mem_wren_i,
    input  logic [2:0]  mem_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] st_data_i,
    output logic        stall_o,
    output logic        fault_o,
    output logic        timeout_o,
    output logic [31:0] ld_data_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_gnt_i,
    input  logic        dmem_rvalid_i,
    input  logic [31:0] dmem_rdata_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10,
        S_DONE = 2'b11
    } state_t;

    // Counter only has to reach TIMEOUT-2 before the abort fires.
    localparam int          CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned LIMIT = (TIMEOUT > 1) ? (TIMEOUT - 1) : 1;

    // Byte enables for a store of the given size at the given byte offset.
    function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] off);
        logic [3:0] be;
        case (op[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the store datum across all lanes so any enabled lane is correct.
    function automatic logic [31:0] store_wdata(input logic [2:0] op, input logic [31:0] st);
        logic [31:0] wd;
        case (op[1:0])
            2'b00:   wd = {4{st[7:0]}};
            2'b01:   wd = {2{st[15:0]}};
            default: wd = st;
        endcase
        return wd;
    endfunction

    // Select the addressed byte/half of the read word and extend it.
    function automatic logic [31:0] load_fmt(input logic [2:0] op, input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'b00:   b = rd[7:0];
            2'b01:   b = rd[15:8];
            2'b10:   b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = off[1] ? rd[31:16] : rd[15:0];
        case (op)
            3'b000:  res = {{24{b[7]}}, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b100:  res = {24'd0, b};
            3'b101:  res = {16'd0, h};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_we;
    logic [31:0]        r_addr;
    logic [3:0]         r_be;
    logic [31:0]        r_wdata;
    logic [2:0]         r_op;
    logic [1:0]         r_off;
    logic [CNT_W-1:0]   r_wd_cnt;
    logic [31:0]        r_ld_data;
    logic               r_timeout;

    logic               w_any;
    logic               w_illegal;
    logic               w_misalign;
    logic               w_fault;
    logic               w_access;
    logic               w_in_idle;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic               w_wd_hit;
    logic               w_req;
    logic               w_stall;
    logic               w_abort;

    assign w_any      = ld_en_i | mem_wren_i;
    // Stores have no unsigned variants, so funct3 bit2 is illegal for them.
    assign w_illegal  = (mem_op_i == 3'b011) | (mem_op_i == 3'b110) | (mem_op_i == 3'b111)
                      | (mem_wren_i & mem_op_i[2]);
    assign w_misalign = ((mem_op_i[1:0] == 2'b01) & addr_i[0])
                      | ((mem_op_i == 3'b010) & (addr_i[1:0] != 2'b00));
    assign w_fault    = w_any & (w_illegal | w_misalign);
    assign w_access   = w_any & ~w_fault;
    assign w_in_idle  = (r_state == S_IDLE);
    assign w_be       = mem_wren_i ? store_be(mem_op_i, addr_i[1:0]) : 4'b1111;
    assign w_wdata    = mem_wren_i ? store_wdata(mem_op_i, st_data_i) : 32'd0;

    // Counter holds cycles spent in REQ/WAIT; the IDLE request cycle is the
    // first allowed cycle, so the abort fires once TIMEOUT cycles are used up.
    assign w_wd_hit   = (TIMEOUT != 32'd0) && ((32'(r_wd_cnt) + 32'd1) >= LIMIT);

    // Next-state decode with Mealy request/stall for the IDLE cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_req       = 1'b1;
                    w_stall     = 1'b1;
                    w_state_nxt = dmem_gnt_i ? S_WAIT : S_REQ;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                w_req   = 1'b1;
                w_stall = 1'b1;
                if (w_wd_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (dmem_gnt_i) begin
                    w_state_nxt = S_WAIT;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_WAIT: begin
                w_stall = 1'b1;
                if (dmem_rvalid_i) begin
                    w_state_nxt = S_DONE;
                end else if (w_wd_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                // Pipeline advances this cycle; the same instruction is still
                // on the inputs, so no request may be raised here.
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Gating by reset_ni drops the Mealy request the instant reset asserts.
    assign dmem_req_o   = reset_ni & w_req;
    assign stall_o      = reset_ni & w_stall;
    assign fault_o      = w_fault;
    assign timeout_o    = r_timeout;
    assign ld_data_o    = r_ld_data;
    assign dmem_we_o    = w_in_idle ? mem_wren_i : r_we;
    assign dmem_addr_o  = w_in_idle ? {addr_i[31:2], 2'b00} : r_addr;
    assign dmem_be_o    = w_in_idle ? w_be : r_be;
    assign dmem_wdata_o = w_in_idle ? w_wdata : r_wdata;

    // FSM state register.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Holding registers keep the request stable until granted.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_op    <= 3'd0;
            r_off   <= 2'd0;
        end else if (w_in_idle && w_access) begin
            r_we    <= mem_wren_i;
            r_addr  <= {addr_i[31:2], 2'b00};
            r_be    <= w_be;
            r_wdata <= w_wdata;
            r_op    <= mem_op_i;
            r_off   <= addr_i[1:0];
        end else begin
            r_we    <= r_we;
            r_addr  <= r_addr;
            r_be    <= r_be;
            r_wdata <= r_wdata;
            r_op    <= r_op;
            r_off   <= r_off;
        end
    end

    // Watchdog: cleared outside REQ/WAIT, counts every cycle inside them.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wd_cnt <= '0;
        end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_wd_cnt <= r_wd_cnt + CNT_W'(1);
        end else begin
            r_wd_cnt <= '0;
        end
    end

    // Load result capture and timeout pulse; an abort zeroes the load data.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_ld_data <= 32'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_abort;
            if ((r_state == S_WAIT) && dmem_rvalid_i && !r_we) begin
                r_ld_data <= load_fmt(r_op, r_off, dmem_rdata_i);
            end else if (w_abort) begin
                r_ld_data <= 32'd0;
            end else begin
                r_ld_data <= r_ld_data;
            end
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
module tb_lsu_mem_ctrl;

    logic        clk = 1'b0;
    logic        reset_ni;

    // main instance (default watchdog)
    logic        ld_en, wren, gnt, rvalid;
    logic [2:0]  op;
    logic [31:0] addr, st_data, rdata;
    logic        stall, fault, tmo, req, we;
    logic [31:0] ld_data, daddr, wdata;
    logic [3:0]  be;

    // short-watchdog instance
    logic        w2_ld_en, w2_gnt, w2_rvalid;
    logic [31:0] w2_rdata;
    logic        w2_stall, w2_fault, w2_tmo, w2_req, w2_we;
    logic [31:0] w2_ld_data, w2_daddr, w2_wdata;
    logic [3:0]  w2_be;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_ld;

    always #5 clk = ~clk;

    lsu_mem_ctrl u_dut (
        .clk_i(clk), .reset_ni(reset_ni), .ld_en_i(ld_en), .mem_wren_i(wren),
        .mem_op_i(op), .addr_i(addr), .st_data_i(st_data), .stall_o(stall),
        .fault_o(fault), .timeout_o(tmo), .ld_data_o(ld_data), .dmem_req_o(req),
        .dmem_we_o(we), .dmem_addr_o(daddr), .dmem_be_o(be), .dmem_wdata_o(wdata),
        .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata)
    );

    lsu_mem_ctrl #(.TIMEOUT(4)) u_dut_wd (
        .clk_i(clk), .reset_ni(reset_ni), .ld_en_i(w2_ld_en), .mem_wren_i(1'b0),
        .mem_op_i(3'b010), .addr_i(32'h0000_0040), .st_data_i(32'd0), .stall_o(w2_stall),
        .fault_o(w2_fault), .timeout_o(w2_tmo), .ld_data_o(w2_ld_data), .dmem_req_o(w2_req),
        .dmem_we_o(w2_we), .dmem_addr_o(w2_daddr), .dmem_be_o(w2_be), .dmem_wdata_o(w2_wdata),
        .dmem_gnt_i(w2_gnt), .dmem_rvalid_i(w2_rvalid), .dmem_rdata_i(w2_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] o, input logic [1:0] off,
                                           input logic [31:0] rd);
        int          sh;
        logic [31:0] b, h;
        sh = off;
        b  = (rd >> (8 * sh)) & 32'h0000_00FF;
        h  = (rd >> (16 * (sh / 2))) & 32'h0000_FFFF;
        case (o)
            3'd0:    return (b >= 32'd128)   ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] o, input logic [31:0] a);
        case (o)
            3'd0:    return 4'(1 << (a % 4));
            3'd1:    return ((a % 4) >= 2) ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] o, input logic [31:0] s);
        case (o)
            3'd0:    return (s & 32'hFF) * 32'h0101_0101;
            3'd1:    return (s & 32'hFFFF) * 32'h0001_0001;
            default: return s;
        endcase
    endfunction

    function automatic logic m_fault(input logic l, input logic s, input logic [2:0] o,
                                     input logic [31:0] a);
        int  size;
        logic illegal, mis;
        if (!(l || s)) return 1'b0;
        if (s) illegal = !(o == 3'd0 || o == 3'd1 || o == 3'd2);
        else   illegal = !(o == 3'd0 || o == 3'd1 || o == 3'd2 || o == 3'd4 || o == 3'd5);
        size = 1 << (o % 4);
        mis  = (size == 2 && (a % 2) != 0) || (size == 4 && (a % 4) != 0);
        return illegal || mis;
    endfunction

    // One full access: grant in cycle g (cycle 0 = first request cycle),
    // response r cycles after grant, then one DONE cycle.
    task automatic do_access(input logic l, input logic s, input logic [2:0] o,
                             input logic [31:0] a, input logic [31:0] sd,
                             input int g, input int r, input logic [31:0] rd);
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        e_be = s ? m_be(o, a) : 4'hF;
        e_wd = m_wdata(o, sd);
        for (int k = 0; k <= g + r + 1; k++) begin
            @(posedge clk); #1;
            ld_en = l; wren = s; op = o; addr = a; st_data = sd;
            gnt    = (k == g);
            rvalid = (k == g + r) ? 1'b1 :
                     ((k < g) || (k == g + r + 1)) ? 1'($urandom_range(0, 1)) : 1'b0;
            rdata  = (k == g + r) ? rd : $urandom();
            @(negedge clk);
            chk("stall", 32'(stall), 32'(k <= g + r));
            chk("req", 32'(req), 32'(k <= g));
            chk("fault_ok", 32'(fault), 32'd0);
            if (k <= g) begin
                chk("dmem_addr", daddr, a & 32'hFFFF_FFFC);
                chk("dmem_be", 32'(be), 32'(e_be));
                chk("dmem_we", 32'(we), 32'(s));
                if (s) chk("dmem_wdata", wdata, e_wd);
            end
        end
        if (!s) exp_ld = m_load(o, a[1:0], rd);
        @(posedge clk); #1;
        ld_en = 1'b0; wren = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        chk("ld_data", ld_data, exp_ld);
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req", 32'(req), 32'd0);
    endtask

    // Presents an instruction that must not start an access.
    task automatic probe(input logic l, input logic s, input logic [2:0] o, input logic [31:0] a);
        logic f;
        f = m_fault(l, s, o, a);
        @(posedge clk); #1;
        ld_en = f ? l : 1'b0; wren = f ? s : 1'b0; op = o; addr = a;
        gnt = 1'($urandom_range(0, 1)); rvalid = 1'($urandom_range(0, 1)); rdata = $urandom();
        @(negedge clk);
        chk("fault", 32'(fault), 32'(f));
        chk("fault_req", 32'(req), 32'd0);
        chk("fault_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        ld_en = 1'b0; wren = 1'b0; gnt = 1'b0; rvalid = 1'b0;
        @(negedge clk);
        chk("fault_ld_kept", ld_data, exp_ld);
    endtask

    task automatic wd_cycle(input logic l, input logic g, input logic v, input logic [31:0] rd);
        @(posedge clk); #1;
        w2_ld_en = l; w2_gnt = g; w2_rvalid = v; w2_rdata = rd;
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       l, s;
        logic [2:0] o;
        logic [31:0] a;
        int          size;

        reset_ni = 1'b0;
        ld_en = 1'b0; wren = 1'b0; op = 3'd0; addr = 32'd0; st_data = 32'd0;
        gnt = 1'b0; rvalid = 1'b0; rdata = 32'd0;
        w2_ld_en = 1'b0; w2_gnt = 1'b0; w2_rvalid = 1'b0; w2_rdata = 32'd0;
        exp_ld = 32'd0;

        // reset state
        #12;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_tmo", 32'(tmo), 32'd0);
        chk("rst_ld", ld_data, 32'd0);
        chk("rst_wd_tmo", 32'(w2_tmo), 32'd0);
        @(negedge clk);
        reset_ni = 1'b1;

        // directed loads / stores
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 0, 1, 32'hDEAD_BEEF);
        chk("lw_val", ld_data, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 1, 32'h80FF_0000);
        chk("lb_val", ld_data, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 1, 2, 32'h80FF_0000);
        chk("lbu_val", ld_data, 32'h0000_0080);
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 0, 1, 32'h80FF_0000);
        chk("lh_val", ld_data, 32'hFFFF_80FF);
        do_access(1'b0, 1'b1, 3'b000, 32'h201, 32'h1234_5678, 3, 2, 32'd0);
        do_access(1'b1, 1'b1, 3'b001, 32'h202, 32'hAAAA_1357, 1, 1, 32'hFFFF_FFFF);
        chk("store_wins_ld", ld_data, 32'hFFFF_80FF);

        // faults
        probe(1'b1, 1'b0, 3'b010, 32'h102);
        probe(1'b1, 1'b0, 3'b011, 32'h100);
        probe(1'b0, 1'b1, 3'b100, 32'h100);
        probe(1'b1, 1'b0, 3'b101, 32'h101);
        probe(1'b0, 1'b0, 3'b111, 32'h103);

        // watchdog with TIMEOUT=4
        wd_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("wd0_req", 32'(w2_req), 32'd1);
        wd_cycle(1'b1, 1'b0, 1'b1, 32'hCAFE_F00D);
        chk("wd0_stall", 32'(w2_stall), 32'd1);
        wd_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("wd0_done_stall", 32'(w2_stall), 32'd0);
        chk("wd0_ld", w2_ld_data, 32'hCAFE_F00D);
        wd_cycle(1'b0, 1'b0, 1'b0, 32'd0);
        wd_cycle(1'b1, 1'b1, 1'b0, 32'd0);
        chk("wd_c0_req", 32'(w2_req), 32'd1);
        chk("wd_c0_tmo", 32'(w2_tmo), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            wd_cycle(1'b1, 1'b0, 1'b0, 32'd0);
            chk("wd_wait_stall", 32'(w2_stall), 32'd1);
            chk("wd_wait_tmo", 32'(w2_tmo), 32'd0);
        end
        wd_cycle(1'b1, 1'b0, 1'b0, 32'd0);
        chk("wd_tmo_pulse", 32'(w2_tmo), 32'd1);
        chk("wd_tmo_stall", 32'(w2_stall), 32'd0);
        chk("wd_tmo_req", 32'(w2_req), 32'd0);
        chk("wd_tmo_ld", w2_ld_data, 32'd0);
        wd_cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678);
        chk("wd_late_tmo", 32'(w2_tmo), 32'd0);
        chk("wd_late_stall", 32'(w2_stall), 32'd0);
        wd_cycle(1'b0, 1'b0, 1'b0, 32'd0);
        chk("wd_late_ld", w2_ld_data, 32'd0);

        // reset while in WAIT
        @(posedge clk); #1;
        ld_en = 1'b1; wren = 1'b0; op = 3'b010; addr = 32'h300; gnt = 1'b1; rvalid = 1'b0;
        @(negedge clk);
        chk("mid_req", 32'(req), 32'd1);
        @(posedge clk); #1;
        gnt = 1'b0;
        @(negedge clk);
        chk("mid_wait_stall", 32'(stall), 32'd1);
        #1 reset_ni = 1'b0;
        #1;
        chk("mid_rst_req", 32'(req), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        ld_en = 1'b0;
        exp_ld = 32'd0;
        @(posedge clk); #1;
        rvalid = 1'b1; rdata = 32'h5555_AAAA;
        @(negedge clk);
        reset_ni = 1'b1;
        @(posedge clk); #1;
        rvalid = 1'b0;
        @(negedge clk);
        chk("stray_stall", 32'(stall), 32'd0);
        chk("stray_ld", ld_data, 32'd0);
        do_access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 2, 1, 32'h0BAD_F00D);
        chk("post_rst_lw", ld_data, 32'h0BAD_F00D);

        // randomized accesses and fault probes
        for (int i = 0; i < 40; i++) begin
            s = 1'($urandom_range(0, 1));
            l = s ? ($urandom_range(0, 3) == 0) : 1'b1;
            if (s) o = 3'($urandom_range(0, 2));
            else begin
                o = 3'($urandom_range(0, 4));
                if (o == 3'd3) o = 3'd5;
            end
            size = 1 << (o % 4);
            a = $urandom() & ~(32'(size) - 32'd1);
            do_access(l, s, o, a, $urandom(), $urandom_range(0, 3), $urandom_range(1, 3),
                      $urandom());
            probe(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), $urandom());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
